// File: rtl/hazard_scoreboard_unit_if.sv
// Bundles the pipeline-facing signals of the hazard/scoreboard unit.
// Latency: none (wires only).
// Backpressure: none; the stall/flush outputs carried here are the backpressure.
interface hazard_scoreboard_unit_if #(
    parameter int REG_AW = 5,
    parameter int PERF_W = 16
);
    // Pipeline status inputs
    logic              ICacheMiss;
    logic              DCacheMiss;
    logic              BranchTakenE;
    logic              JalrE;
    logic              JalD;
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic [REG_AW-1:0] RdD;
    logic [1:0]        RegReadD;
    logic              RegWriteD;
    logic [REG_AW-1:0] Rs1E;
    logic [REG_AW-1:0] Rs2E;
    logic [REG_AW-1:0] RdE;
    logic [1:0]        RegReadE;
    logic              MemToRegE;
    logic              MdIssueE;
    logic [REG_AW-1:0] RdM;
    logic [REG_AW-1:0] RdW;
    logic              RegWriteM;
    logic              RegWriteW;
    logic              MdWbAck;
    logic              PerfClr;

    // Hazard unit outputs
    logic              StallF, StallD, StallE, StallM, StallW;
    logic              FlushF, FlushD, FlushE, FlushM, FlushW;
    logic [1:0]        Forward1E;
    logic [1:0]        Forward2E;
    logic              MdBusy;
    logic              MdWbValid;
    logic [REG_AW-1:0] MdWbRd;
    logic [PERF_W-1:0] StallCnt;
    logic [PERF_W-1:0] FlushCnt;

    // Pipeline side
    modport master (
        output ICacheMiss, DCacheMiss, BranchTakenE, JalrE, JalD,
        output Rs1D, Rs2D, RdD, RegReadD, RegWriteD,
        output Rs1E, Rs2E, RdE, RegReadE, MemToRegE, MdIssueE,
        output RdM, RdW, RegWriteM, RegWriteW, MdWbAck, PerfClr,
        input  StallF, StallD, StallE, StallM, StallW,
        input  FlushF, FlushD, FlushE, FlushM, FlushW,
        input  Forward1E, Forward2E, MdBusy, MdWbValid, MdWbRd,
        input  StallCnt, FlushCnt
    );

    // Hazard unit side
    modport slave (
        input  ICacheMiss, DCacheMiss, BranchTakenE, JalrE, JalD,
        input  Rs1D, Rs2D, RdD, RegReadD, RegWriteD,
        input  Rs1E, Rs2E, RdE, RegReadE, MemToRegE, MdIssueE,
        input  RdM, RdW, RegWriteM, RegWriteW, MdWbAck, PerfClr,
        output StallF, StallD, StallE, StallM, StallW,
        output FlushF, FlushD, FlushE, FlushM, FlushW,
        output Forward1E, Forward2E, MdBusy, MdWbValid, MdWbRd,
        output StallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: stall/flush, EX forwarding, one-entry mul/div scoreboard, perf counters.
// Latency: stall/flush/forward are combinational; scoreboard and counters update on the next edge.
// Backpressure: mul/div result is held with MdWbValid high until MdWbAck; pipeline held via Stall*.
module hazard_scoreboard_unit #(
    parameter int REG_AW     = 5,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 4,
    parameter int PERF_W     = 16
) (
    input  logic                  clk,
    input  logic                  CpuRst,
    hazard_scoreboard_unit_if.slave hz
);

    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MD_LATENCY - 1);
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    // Encoded in the order {SF,FF,SD,FD,SE,FE,SM,FM,SW,FW}
    localparam logic [9:0] SF_RESET  = 10'b0101010101;
    localparam logic [9:0] SF_FREEZE = 10'b1010101010;
    localparam logic [9:0] SF_REDIR  = 10'b0001010000;
    localparam logic [9:0] SF_STRUCT = 10'b1010100100;
    localparam logic [9:0] SF_BUBBLE = 10'b1010010000;
    localparam logic [9:0] SF_JAL    = 10'b0001000000;

    // Scoreboard and counter state
    logic              md_busy_q,   md_busy_d;
    logic [REG_AW-1:0] md_rd_q,     md_rd_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       md_wb_valid;
    logic       md_retire;
    logic       md_free;
    logic       md_accept;
    logic       cache_miss;
    logic       redirect;
    logic       struct_haz;
    logic       load_use;
    logic       md_dep;
    logic       redirect_fire;
    logic [9:0] sf_vec;

    // Forward select for one EX source: MEM result wins over WB result
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              used,
        input logic              wr_m,
        input logic [REG_AW-1:0] rd_m,
        input logic              wr_w,
        input logic [REG_AW-1:0] rd_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used && wr_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (used && wr_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign md_wb_valid = md_busy_q && (cnt_q == '0);
    assign md_retire   = md_wb_valid && hz.MdWbAck;
    assign md_free     = !md_busy_q || md_retire;

    assign cache_miss = hz.ICacheMiss || hz.DCacheMiss;
    assign redirect   = hz.BranchTakenE || hz.JalrE;

    // A second mul/div cannot enter the unit while the entry is still occupied
    assign struct_haz = hz.MdIssueE && md_busy_q && !md_retire;

    assign load_use = hz.MemToRegE && (hz.RdE != '0) &&
                      ((hz.RegReadD[1] && (hz.Rs1D == hz.RdE)) ||
                       (hz.RegReadD[0] && (hz.Rs2D == hz.RdE)));

    // ID reads the pending mul/div destination (RAW) or would overwrite it first (WAW)
    assign md_dep = md_busy_q && (md_rd_q != '0) &&
                    ((hz.RegReadD[1] && (hz.Rs1D == md_rd_q)) ||
                     (hz.RegReadD[0] && (hz.Rs2D == md_rd_q)) ||
                     (hz.RegWriteD   && (hz.RdD  == md_rd_q)));

    // Priority-ordered stall/flush selection; first matching cause wins
    always_comb begin
        sf_vec        = '0;
        redirect_fire = 1'b0;
        if (CpuRst) begin
            sf_vec = SF_RESET;
        end else if (cache_miss) begin
            sf_vec = SF_FREEZE;
        end else if (redirect) begin
            sf_vec        = SF_REDIR;
            redirect_fire = 1'b1;
        end else if (struct_haz) begin
            sf_vec = SF_STRUCT;
        end else if (load_use) begin
            sf_vec = SF_BUBBLE;
        end else if (md_dep) begin
            sf_vec = SF_BUBBLE;
        end else if (hz.JalD) begin
            sf_vec = SF_JAL;
        end
    end

    assign {hz.StallF, hz.FlushF, hz.StallD, hz.FlushD, hz.StallE,
            hz.FlushE, hz.StallM, hz.FlushM, hz.StallW, hz.FlushW} = sf_vec;

    assign hz.Forward1E = fwd_sel(hz.Rs1E, hz.RegReadE[1], hz.RegWriteM, hz.RdM,
                                  hz.RegWriteW, hz.RdW);
    assign hz.Forward2E = fwd_sel(hz.Rs2E, hz.RegReadE[0], hz.RegWriteM, hz.RdM,
                                  hz.RegWriteW, hz.RdW);

    // Only an instruction actually leaving EX this cycle may claim the entry
    assign md_accept = hz.MdIssueE && !sf_vec[5] && !sf_vec[4] &&
                       (hz.RdE != '0) && md_free;

    // Scoreboard next state: accept overrides retire so back-to-back ops keep MdBusy high
    always_comb begin
        md_busy_d = md_busy_q;
        md_rd_d   = md_rd_q;
        cnt_d     = cnt_q;
        if (md_accept) begin
            md_busy_d = 1'b1;
            md_rd_d   = hz.RdE;
            cnt_d     = CNT_INIT;
        end else begin
            if (md_retire) begin
                md_busy_d = 1'b0;
            end
            // Counting is independent of pipeline freezes; the mul/div unit runs free
            if (md_busy_q && (cnt_q != '0)) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Saturating performance counters; clear beats increment
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.PerfClr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (sf_vec[9] && (stall_cnt_q != PERF_MAX)) begin
                stall_cnt_d = stall_cnt_q + PERF_W'(1);
            end
            if (redirect_fire && (flush_cnt_q != PERF_MAX)) begin
                flush_cnt_d = flush_cnt_q + PERF_W'(1);
            end
        end
    end

    // State registers; reset drops any in-flight mul/div
    always_ff @(posedge clk) begin
        if (CpuRst) begin
            md_busy_q   <= 1'b0;
            md_rd_q     <= '0;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            md_busy_q   <= md_busy_d;
            md_rd_q     <= md_rd_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.MdBusy    = md_busy_q;
    assign hz.MdWbValid = md_wb_valid;
    assign hz.MdWbRd    = md_rd_q;
    assign hz.StallCnt  = stall_cnt_q;
    assign hz.FlushCnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit.
// Latency: checks combinational outputs in the driven cycle, registered state one edge later.
// Backpressure: exercises held MdWbValid without MdWbAck and structural stalls.
module tb_hazard_scoreboard_unit;

    localparam int PW = 8;

    logic clk;
    logic CpuRst;
    int   n_vec;
    int   n_fail;

    hazard_scoreboard_unit_if #(.REG_AW(5), .PERF_W(PW)) hz ();

    hazard_scoreboard_unit #(
        .REG_AW    (5),
        .MD_LATENCY(4),
        .CNT_W     (4),
        .PERF_W    (PW)
    ) dut (
        .clk   (clk),
        .CpuRst(CpuRst),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] sf_obs;
    assign sf_obs = {hz.StallF, hz.FlushF, hz.StallD, hz.FlushD, hz.StallE,
                     hz.FlushE, hz.StallM, hz.FlushM, hz.StallW, hz.FlushW};

    typedef struct {
        logic       icm, dcm, bte, jalr, jald;
        logic [4:0] rs1d, rs2d, rdd;
        logic [1:0] rrd;
        logic       rwd;
        logic [4:0] rs1e, rs2e, rde;
        logic [1:0] rre;
        logic       mtr;
        logic [4:0] rdm, rdw;
        logic       rwm, rww;
        logic [9:0] exp_sf;
        logic [1:0] exp_f1, exp_f2;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        hz.ICacheMiss = 0; hz.DCacheMiss = 0; hz.BranchTakenE = 0; hz.JalrE = 0;
        hz.JalD = 0; hz.Rs1D = 0; hz.Rs2D = 0; hz.RdD = 0; hz.RegReadD = 0;
        hz.RegWriteD = 0; hz.Rs1E = 0; hz.Rs2E = 0; hz.RdE = 0; hz.RegReadE = 0;
        hz.MemToRegE = 0; hz.MdIssueE = 0; hz.RdM = 0; hz.RdW = 0;
        hz.RegWriteM = 0; hz.RegWriteW = 0; hz.MdWbAck = 0; hz.PerfClr = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec  = 0;
        n_fail = 0;
        clear_in();
        CpuRst = 1'b1;

        // ---------------- reset state ----------------
        tick();
        @(negedge clk);
        chk("rst_sf", 32'(sf_obs), 32'(10'b0101010101));
        chk("rst_busy", 32'(hz.MdBusy), 0);
        chk("rst_wbvalid", 32'(hz.MdWbValid), 0);
        chk("rst_stallcnt", 32'(hz.StallCnt), 0);
        chk("rst_flushcnt", 32'(hz.FlushCnt), 0);
        chk("rst_fwd1", 32'(hz.Forward1E), 0);
        tick();
        CpuRst = 1'b0;

        // ---------------- combinational table ----------------
        //          icm dcm bte jalr jald rs1d rs2d rdd rrd  rwd rs1e rs2e rde rre  mtr rdm rdw rwm rww exp_sf         f1     f2
        tbl.push_back('{0,0,0,0,0, 0,0,0,2'b00,0, 0,0,0,2'b00,0, 0,0,0,0, 10'b0000000000, 2'b00, 2'b00});
        tbl.push_back('{1,0,0,0,0, 0,0,0,2'b00,0, 0,0,0,2'b00,0, 0,0,0,0, 10'b1010101010, 2'b00, 2'b00});
        tbl.push_back('{0,1,1,0,0, 0,0,0,2'b00,0, 0,0,0,2'b00,0, 0,0,0,0, 10'b1010101010, 2'b00, 2'b00});
        tbl.push_back('{0,0,1,0,0, 0,0,0,2'b00,0, 0,0,0,2'b00,0, 0,0,0,0, 10'b0001010000, 2'b00, 2'b00});
        tbl.push_back('{0,0,0,1,1, 0,0,0,2'b00,0, 0,0,0,2'b00,0, 0,0,0,0, 10'b0001010000, 2'b00, 2'b00});
        tbl.push_back('{0,0,0,0,1, 0,0,0,2'b00,0, 0,0,0,2'b00,0, 0,0,0,0, 10'b0001000000, 2'b00, 2'b00});
        tbl.push_back('{0,0,0,0,0, 3,0,0,2'b10,0, 0,0,3,2'b00,1, 0,0,0,0, 10'b1010010000, 2'b00, 2'b00});
        tbl.push_back('{0,0,0,0,0, 0,3,0,2'b01,0, 0,0,3,2'b00,1, 0,0,0,0, 10'b1010010000, 2'b00, 2'b00});
        tbl.push_back('{0,0,0,0,0, 3,4,0,2'b01,0, 0,0,3,2'b00,1, 0,0,0,0, 10'b0000000000, 2'b00, 2'b00});
        tbl.push_back('{0,0,0,0,0, 0,0,0,2'b11,0, 0,0,0,2'b00,1, 0,0,0,0, 10'b0000000000, 2'b00, 2'b00});
        tbl.push_back('{0,0,0,0,1, 0,6,0,2'b01,0, 0,0,6,2'b00,1, 0,0,0,0, 10'b1010010000, 2'b00, 2'b00});
        tbl.push_back('{0,0,0,0,0, 0,0,0,2'b00,0, 7,0,0,2'b10,0, 7,7,1,1, 10'b0000000000, 2'b10, 2'b00});
        tbl.push_back('{0,0,0,0,0, 0,0,0,2'b00,0, 7,0,0,2'b10,0, 0,7,1,1, 10'b0000000000, 2'b01, 2'b00});
        tbl.push_back('{0,0,0,0,0, 0,0,0,2'b00,0, 7,7,0,2'b01,0, 7,7,1,1, 10'b0000000000, 2'b00, 2'b10});
        tbl.push_back('{0,0,0,0,0, 0,0,0,2'b00,0, 7,7,0,2'b11,0, 7,7,0,1, 10'b0000000000, 2'b01, 2'b01});
        tbl.push_back('{0,0,0,0,0, 0,0,0,2'b00,0, 8,7,0,2'b11,0, 8,7,1,0, 10'b0000000000, 2'b10, 2'b00});
        tbl.push_back('{0,0,0,0,0, 0,0,0,2'b00,0, 7,7,0,2'b11,0, 7,7,0,0, 10'b0000000000, 2'b00, 2'b00});

        for (int i = 0; i < tbl.size(); i++) begin
            hz.ICacheMiss = tbl[i].icm; hz.DCacheMiss = tbl[i].dcm;
            hz.BranchTakenE = tbl[i].bte; hz.JalrE = tbl[i].jalr; hz.JalD = tbl[i].jald;
            hz.Rs1D = tbl[i].rs1d; hz.Rs2D = tbl[i].rs2d; hz.RdD = tbl[i].rdd;
            hz.RegReadD = tbl[i].rrd; hz.RegWriteD = tbl[i].rwd;
            hz.Rs1E = tbl[i].rs1e; hz.Rs2E = tbl[i].rs2e; hz.RdE = tbl[i].rde;
            hz.RegReadE = tbl[i].rre; hz.MemToRegE = tbl[i].mtr;
            hz.RdM = tbl[i].rdm; hz.RdW = tbl[i].rdw;
            hz.RegWriteM = tbl[i].rwm; hz.RegWriteW = tbl[i].rww;
            @(negedge clk);
            chk($sformatf("vec%0d_sf", i), 32'(sf_obs), 32'(tbl[i].exp_sf));
            chk($sformatf("vec%0d_fwd1", i), 32'(hz.Forward1E), 32'(tbl[i].exp_f1));
            chk($sformatf("vec%0d_fwd2", i), 32'(hz.Forward2E), 32'(tbl[i].exp_f2));
            tick();
        end
        clear_in();
        tick();

        // ---------------- T1: issue mul x5, ack held high ----------------
        hz.MdIssueE = 1; hz.RdE = 5; hz.MdWbAck = 1;
        @(negedge clk);
        chk("t1_issue_sf", 32'(sf_obs), 0);
        chk("t1_issue_busy", 32'(hz.MdBusy), 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) hz.MdIssueE = 0;
            @(negedge clk);
            chk($sformatf("t1_busy_c%0d", k), 32'(hz.MdBusy), 1);
            chk($sformatf("t1_valid_c%0d", k), 32'(hz.MdWbValid), (k == 4) ? 1 : 0);
        end
        chk("t1_wbrd", 32'(hz.MdWbRd), 5);
        tick();
        @(negedge clk);
        chk("t1_retired_busy", 32'(hz.MdBusy), 0);
        chk("t1_retired_valid", 32'(hz.MdWbValid), 0);
        clear_in();
        tick();

        // ---------------- T2: RAW on pending mul x5 ----------------
        hz.MdIssueE = 1; hz.RdE = 5;
        @(negedge clk);
        chk("t2_issue_sf", 32'(sf_obs), 0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                hz.MdIssueE = 0; hz.RdE = 0;
                hz.Rs1D = 5; hz.RegReadD = 2'b10;
            end
            @(negedge clk);
            chk($sformatf("t2_stall_c%0d", k), 32'(sf_obs), 32'(10'b1010010000));
            chk($sformatf("t2_valid_c%0d", k), 32'(hz.MdWbValid), (k >= 4) ? 1 : 0);
        end
        tick();
        hz.MdWbAck = 1;
        @(negedge clk);
        chk("t2_retire_cycle_sf", 32'(sf_obs), 32'(10'b1010010000));
        tick();
        hz.MdWbAck = 0; hz.Rs1D = 0; hz.RegReadD = 0;
        hz.Rs1E = 5; hz.RegReadE = 2'b10; hz.RdW = 5; hz.RegWriteW = 1;
        @(negedge clk);
        chk("t2_after_busy", 32'(hz.MdBusy), 0);
        chk("t2_after_sf", 32'(sf_obs), 0);
        chk("t2_after_fwd1", 32'(hz.Forward1E), 1);
        clear_in();
        tick();

        // ---------------- T3: structural stall, then T6 reset mid-operation ----------------
        hz.MdIssueE = 1; hz.RdE = 5;
        @(negedge clk);
        chk("t3_first_sf", 32'(sf_obs), 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) hz.RdE = 6;
            @(negedge clk);
            chk($sformatf("t3_struct_c%0d", k), 32'(sf_obs), 32'(10'b1010100100));
        end
        chk("t3_held_rd", 32'(hz.MdWbRd), 5);
        chk("t3_held_valid", 32'(hz.MdWbValid), 1);
        tick();
        hz.MdWbAck = 1;
        @(negedge clk);
        chk("t3_ack_sf", 32'(sf_obs), 0);
        tick();
        hz.MdWbAck = 0; hz.MdIssueE = 0; hz.RdE = 0;
        @(negedge clk);
        chk("t3_second_busy", 32'(hz.MdBusy), 1);
        chk("t3_second_rd", 32'(hz.MdWbRd), 6);
        chk("t3_second_valid", 32'(hz.MdWbValid), 0);
        tick();
        CpuRst = 1;
        @(negedge clk);
        chk("t6_rst_sf", 32'(sf_obs), 32'(10'b0101010101));
        tick();
        @(negedge clk);
        chk("t6_busy", 32'(hz.MdBusy), 0);
        chk("t6_valid", 32'(hz.MdWbValid), 0);
        chk("t6_stallcnt", 32'(hz.StallCnt), 0);
        chk("t6_flushcnt", 32'(hz.FlushCnt), 0);
        chk("t6_sf", 32'(sf_obs), 32'(10'b0101010101));
        tick();
        CpuRst = 0;
        @(negedge clk);
        chk("t6_post_sf", 32'(sf_obs), 0);
        chk("t6_post_busy", 32'(hz.MdBusy), 0);

        // ---------------- T5: D-cache miss over a taken branch ----------------
        tick();
        hz.PerfClr = 1;
        tick();
        hz.PerfClr = 0;
        hz.DCacheMiss = 1; hz.BranchTakenE = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("t5_freeze_c%0d", k), 32'(sf_obs), 32'(10'b1010101010));
            tick();
        end
        hz.DCacheMiss = 0;
        @(negedge clk);
        chk("t5_redirect_sf", 32'(sf_obs), 32'(10'b0001010000));
        tick();
        hz.BranchTakenE = 0;
        @(negedge clk);
        chk("t5_stallcnt", 32'(hz.StallCnt), 5);
        chk("t5_flushcnt", 32'(hz.FlushCnt), 1);

        // ---------------- counter saturation and clear priority ----------------
        tick();
        hz.ICacheMiss = 1;
        for (int k = 0; k < 260; k++) tick();
        hz.ICacheMiss = 0;
        @(negedge clk);
        chk("sat_stallcnt", 32'(hz.StallCnt), 32'(2 ** PW - 1));
        tick();
        hz.BranchTakenE = 1;
        for (int k = 0; k < 260; k++) tick();
        hz.BranchTakenE = 0;
        @(negedge clk);
        chk("sat_flushcnt", 32'(hz.FlushCnt), 32'(2 ** PW - 1));
        tick();
        hz.PerfClr = 1; hz.ICacheMiss = 1; hz.BranchTakenE = 1;
        tick();
        hz.PerfClr = 0; hz.ICacheMiss = 0; hz.BranchTakenE = 0;
        @(negedge clk);
        chk("clr_prio_stallcnt", 32'(hz.StallCnt), 0);
        chk("clr_prio_flushcnt", 32'(hz.FlushCnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
